// File: rtl/cpu_ctrl_pkg.sv
// Opcodes, FSM state encoding, instruction classes and the datapath strobe bundle
// shared by control_unit and its instruction decoder.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_RSVD = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  typedef enum logic [3:0] {
    S_RESET = 4'd0, T0, T1, T2, T3, T4, T5, T6, T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    ALU_R, ALU_I, MULDIV, UNARY, LDI, LD, ST, BR, JR, IN, OUT, MFHI, MFLO, NOP, HALT
  } instr_class_t;

  typedef struct packed {
    logic pco, pci, incpc, iri, mari, mdri, mdro, mem_read, mem_write;
    logic ryi, rzi, rzlo, rzho, hii, loi, hio, loo;
    logic gra, grb, grc, rin, rout, baout, csigno, ipo, opi, coni;
  } strobes_t;

endpackage

// File: rtl/ir_decode.sv
// Combinational opcode-to-class decoder; unknown and reserved opcodes behave as nop.
module ir_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0]   opcode,
  output instr_class_t iclass
);

  always_comb begin
    iclass = NOP;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: iclass = ALU_R;
      OP_ADDI, OP_ANDI, OP_ORI:       iclass = ALU_I;
      OP_MUL, OP_DIV:                 iclass = MULDIV;
      OP_NEG, OP_NOT:                 iclass = UNARY;
      OP_LDI:                         iclass = LDI;
      OP_LD:                          iclass = LD;
      OP_ST:                          iclass = ST;
      OP_BR:                          iclass = BR;
      OP_JR:                          iclass = JR;
      OP_IN:                          iclass = IN;
      OP_OUT:                         iclass = OUT;
      OP_MFHI:                        iclass = MFHI;
      OP_MFLO:                        iclass = MFLO;
      OP_HALT:                        iclass = HALT;
      OP_NOP, OP_RSVD:                iclass = NOP;
      default:                        iclass = NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired T-step sequencer: fetches into the IR, then drives the datapath strobes
// for each instruction class, stalling in memory steps until mem_ready.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter logic [4:0] ADD_OP = 5'b00011
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        mem_ready,
  output logic        pco, pci, incpc, iri, mari, mdri, mdro, mem_read, mem_write,
  output logic        ryi, rzi, rzlo, rzho, hii, loi, hio, loo,
  output logic        gra, grb, grc, rin, rout, baout, csigno, ipo, opi, coni,
  output logic [4:0]  alu_op,
  output logic        run
);

  state_t       state_q, state_d;
  instr_class_t iclass;
  strobes_t     st;
  logic [4:0]   opcode;
  logic         unused_ir_fields;

  assign opcode           = ir[31:27];
  assign unused_ir_fields = ^ir[26:0];

  ir_decode u_decode (
    .opcode (opcode),
    .iclass (iclass)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = T0;
      T0:      state_d = T1;
      T1:      state_d = mem_ready ? T2 : T1;
      T2:      state_d = T3;
      T3: begin
        case (iclass)
          HALT:                         state_d = S_HALT;
          JR, IN, OUT, MFHI, MFLO, NOP: state_d = T0;
          default:                      state_d = T4;
        endcase
      end
      T4:      state_d = (iclass == UNARY) ? T0 : T5;
      T5: begin
        case (iclass)
          ALU_R, ALU_I, LDI: state_d = T0;
          default:           state_d = T6;
        endcase
      end
      T6: begin
        case (iclass)
          LD:      state_d = mem_ready ? T7 : T6;
          ST:      state_d = T7;
          default: state_d = T0;
        endcase
      end
      T7: begin
        if (iclass == ST) state_d = mem_ready ? T0 : T7;
        else              state_d = T0;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  // Step table indexed by state and instruction class; anything not set stays low.
  always_comb begin
    st     = '0;
    alu_op = '0;
    case (state_q)
      T0: begin st.pco = 1'b1; st.mari = 1'b1; st.incpc = 1'b1; st.rzi = 1'b1; end
      T1: begin st.rzlo = 1'b1; st.pci = 1'b1; st.mem_read = 1'b1; st.mdri = 1'b1; end
      T2: begin st.mdro = 1'b1; st.iri = 1'b1; end
      T3: begin
        case (iclass)
          ALU_R, ALU_I: begin st.grb = 1'b1; st.rout = 1'b1; st.ryi = 1'b1; end
          MULDIV:       begin st.gra = 1'b1; st.rout = 1'b1; st.ryi = 1'b1; end
          UNARY: begin
            st.grb = 1'b1; st.rout = 1'b1; st.rzi = 1'b1; alu_op = opcode;
          end
          LDI, LD, ST:  begin st.grb = 1'b1; st.baout = 1'b1; st.ryi = 1'b1; end
          BR:           begin st.gra = 1'b1; st.rout = 1'b1; st.coni = 1'b1; end
          JR:           begin st.gra = 1'b1; st.rout = 1'b1; st.pci = 1'b1; end
          IN:           begin st.ipo = 1'b1; st.gra = 1'b1; st.rin = 1'b1; end
          OUT:          begin st.gra = 1'b1; st.rout = 1'b1; st.opi = 1'b1; end
          MFHI:         begin st.hio = 1'b1; st.gra = 1'b1; st.rin = 1'b1; end
          MFLO:         begin st.loo = 1'b1; st.gra = 1'b1; st.rin = 1'b1; end
          default:      ;
        endcase
      end
      T4: begin
        case (iclass)
          ALU_R: begin st.grc = 1'b1; st.rout = 1'b1; st.rzi = 1'b1; alu_op = opcode; end
          ALU_I: begin st.csigno = 1'b1; st.rzi = 1'b1; alu_op = opcode; end
          MULDIV: begin st.grb = 1'b1; st.rout = 1'b1; st.rzi = 1'b1; alu_op = opcode; end
          UNARY: begin st.rzlo = 1'b1; st.gra = 1'b1; st.rin = 1'b1; end
          LDI, LD, ST: begin st.csigno = 1'b1; st.rzi = 1'b1; alu_op = ADD_OP; end
          BR:    begin st.pco = 1'b1; st.ryi = 1'b1; end
          default: ;
        endcase
      end
      T5: begin
        case (iclass)
          ALU_R, ALU_I, LDI: begin st.rzlo = 1'b1; st.gra = 1'b1; st.rin = 1'b1; end
          MULDIV: begin st.rzlo = 1'b1; st.loi = 1'b1; end
          LD, ST: begin st.rzlo = 1'b1; st.mari = 1'b1; end
          BR:     begin st.csigno = 1'b1; st.rzi = 1'b1; alu_op = ADD_OP; end
          default: ;
        endcase
      end
      T6: begin
        case (iclass)
          MULDIV: begin st.rzho = 1'b1; st.hii = 1'b1; end
          LD:     begin st.mem_read = 1'b1; st.mdri = 1'b1; end
          ST:     begin st.gra = 1'b1; st.rout = 1'b1; st.mdri = 1'b1; end
          // Branch is taken by loading the computed target only when the condition held.
          BR:     begin st.rzlo = 1'b1; st.pci = con_ff; end
          default: ;
        endcase
      end
      T7: begin
        case (iclass)
          LD:      begin st.mdro = 1'b1; st.gra = 1'b1; st.rin = 1'b1; end
          ST:      st.mem_write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign run = (state_q != S_RESET) && (state_q != S_HALT);

  assign pco = st.pco;             assign pci = st.pci;         assign incpc = st.incpc;
  assign iri = st.iri;             assign mari = st.mari;       assign mdri = st.mdri;
  assign mdro = st.mdro;           assign mem_read = st.mem_read;
  assign mem_write = st.mem_write; assign ryi = st.ryi;         assign rzi = st.rzi;
  assign rzlo = st.rzlo;           assign rzho = st.rzho;       assign hii = st.hii;
  assign loi = st.loi;             assign hio = st.hio;         assign loo = st.loo;
  assign gra = st.gra;             assign grb = st.grb;         assign grc = st.grc;
  assign rin = st.rin;             assign rout = st.rout;       assign baout = st.baout;
  assign csigno = st.csigno;       assign ipo = st.ipo;         assign opi = st.opi;
  assign coni = st.coni;

endmodule
